seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter TICK_DIV, default 131072, clock cycles per digit slot; legal range 2..2^24.
REQ-003 Parameter BLANK_CYCLES, default 16, cycles at the start of each slot with all digits off; legal range 0..TICK_DIV-1.
REQ-004 Parameter ACTIVE_LOW, default 1; when 1, segments and digitselect are inverted at the output.
REQ-005 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 load  input  1  one-cycle strobe that captures digits_in and dp_in.
REQ-008 digits_in  input  4*NUM_DIGITS  hex digit values; digit k occupies bits [4k+3:4k]; digit 0 is least significant.
REQ-009 dp_in  input  NUM_DIGITS  decimal point enable per digit.
REQ-010 segments  output  8  registered; bit7=a ... bit1=g, bit0=dp; logical 1 = lit before polarity.
REQ-011 digitselect  output  NUM_DIGITS  registered; one-hot enable of the current digit, logical 1 = on before polarity.
REQ-012 frame_done  output  1  one-cycle pulse at the end of each full scan.

Function
REQ-013 A tick counter SHALL count 0..TICK_DIV-1 and wrap; on wrap, the digit index SHALL advance, wrapping NUM_DIGITS-1 -> 0.
REQ-014 While the tick counter is < BLANK_CYCLES, digitselect SHALL be all-off and segments all-off.
REQ-015 Otherwise digitselect SHALL select the current index, and segments SHALL decode the displayed digit at that index.
REQ-016 Outputs SHALL lag the index/counter state by exactly one clock.
REQ-017 Decode SHALL be 0-9 standard; 10-15 SHALL be A,b,C,d,E,F; dp SHALL follow the displayed dp bit.
REQ-018 load SHALL write a shadow register and set pending; a load while pending is set SHALL overwrite the shadow (last wins).
REQ-019 The display register SHALL update only at the frame boundary, defined as the cycle where index = NUM_DIGITS-1 and the tick wraps.
REQ-020 At that boundary, display SHALL take digits_in/dp_in if load is high that cycle; otherwise it SHALL take the shadow if pending is set. pending SHALL then clear.
REQ-021 frame_done SHALL pulse high for one cycle, registered, in the cycle after each frame boundary.
REQ-022 When NUM_DIGITS=1, the index SHALL stay 0, and every tick wrap SHALL be a frame boundary.

Reset
REQ-023 reset SHALL clear the tick counter, index, shadow, display register, pending and frame_done to 0.
REQ-024 During reset and on the first cycle after it, digitselect and segments SHALL be all-off at the physical level: all 1s when ACTIVE_LOW=1, all 0s otherwise.
REQ-025 reset mid-frame SHALL discard pending data; scanning SHALL restart at digit 0, tick 0.

Configuration
REQ-026 Macro SEG_LZ_BLANK_EN: when defined, leading-zero suppression SHALL be compiled in.
REQ-027 With SEG_LZ_BLANK_EN, a digit SHALL be blank (segments off except its dp) if it and all more-significant digits are 0; digit 0 SHALL never be blanked.
REQ-028 Without SEG_LZ_BLANK_EN, all digits SHALL always display, and no suppression logic SHALL exist.

Verification (NUM_DIGITS=4, TICK_DIV=4, BLANK_CYCLES=1, ACTIVE_LOW=1)
REQ-029 Reset, then run 16 cycles -> digitselect goes 1111, then 1110 for 3 cycles; blank/select repeats for each digit 0..3; segments show 0 = 00000011 when selected; one frame_done pulse.
REQ-030 load digits_in=16'h12AF mid-frame -> display unchanged until the frame boundary; next frame shows F,A,2,1 on digits 0..3 (F=01110001, A=00010001).
REQ-031 Two loads in one frame, 16'h1111 then 16'h2222 -> next frame shows 2222 only; 1111 is never displayed.
REQ-032 load 16'h0305 asserted exactly on the boundary cycle -> 0305 is displayed in the following frame; pending is 0 afterwards.
REQ-033 reset asserted at tick 2 of digit 2 with a pending load -> next cycle outputs all-off; scan restarts at digit 0 showing 0000.
REQ-034 With SEG_LZ_BLANK_EN, load 16'h0040 with dp_in=4'b1000 -> digit 3 shows only dp (11111110), digit 2 is blank, digit 1 shows 4, digit 0 shows 0.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner; the display register updates only at frame boundaries.
// Optional leading-zero suppression is compiled in when SEG_LZ_BLANK_EN is defined.
module seg_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int TICK_DIV     = 131072,
   parameter int BLANK_CYCLES = 16,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   output logic [7:0]              segments,
   output logic [NUM_DIGITS-1:0]   digitselect,
   output logic                    frame_done
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [TW-1:0]         TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
   localparam logic [7:0]            SEG_OFF   = {8{ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] SEL_OFF   = {NUM_DIGITS{ACTIVE_LOW}};

   logic [TW-1:0]           tick;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] shadow;
   logic [NUM_DIGITS-1:0]   shadow_dp;
   logic                    pending;
   logic [4*NUM_DIGITS-1:0] disp;
   logic [NUM_DIGITS-1:0]   disp_dp;
   logic                    wrap;
   logic                    boundary;
   logic                    in_blank;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic [7:0]              seg_p0;
   logic [NUM_DIGITS-1:0]   sel_p0;

   // Segment order a..g, most significant first.
   function automatic logic [6:0] decode7(input logic [3:0] v);
      case (v)
         4'h0:    decode7 = 7'b1111110;
         4'h1:    decode7 = 7'b0110000;
         4'h2:    decode7 = 7'b1101101;
         4'h3:    decode7 = 7'b1111001;
         4'h4:    decode7 = 7'b0110011;
         4'h5:    decode7 = 7'b1011011;
         4'h6:    decode7 = 7'b1011111;
         4'h7:    decode7 = 7'b1110000;
         4'h8:    decode7 = 7'b1111111;
         4'h9:    decode7 = 7'b1111011;
         4'hA:    decode7 = 7'b1110111;
         4'hB:    decode7 = 7'b0011111;
         4'hC:    decode7 = 7'b1001110;
         4'hD:    decode7 = 7'b0111101;
         4'hE:    decode7 = 7'b1001111;
         default: decode7 = 7'b1000111;
      endcase
   endfunction

   assign wrap     = (tick == TICK_LAST);
   assign boundary = wrap && (idx == IDX_LAST);

   generate
      if (BLANK_CYCLES > 0) begin : g_blank
         assign in_blank = (32'(tick) < 32'(BLANK_CYCLES));
      end else begin : g_no_blank
         assign in_blank = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         tick       <= '0;
         idx        <= '0;
         shadow     <= '0;
         shadow_dp  <= '0;
         pending    <= 1'b0;
         disp       <= '0;
         disp_dp    <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= boundary;
         if (wrap) begin
            tick <= '0;
            idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            tick <= tick + 1'b1;
         end
         if (load) begin
            shadow    <= digits_in;
            shadow_dp <= dp_in;
            pending   <= 1'b1;
         end
         // A load on the boundary cycle bypasses the shadow; the clear wins over the set.
         if (boundary) begin
            if (load) begin
               disp    <= digits_in;
               disp_dp <= dp_in;
            end else if (pending) begin
               disp    <= shadow;
               disp_dp <= shadow_dp;
            end
            pending <= 1'b0;
         end
      end
   end

   always_comb begin
      cur_nib = 4'd0;
      cur_dp  = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == IW'(k)) begin
            cur_nib = disp[4*k +: 4];
            cur_dp  = disp_dp[k];
         end
      end
   end

`ifdef SEG_LZ_BLANK_EN
   logic lz_blank;

   // Digit 0 is never a candidate, so a zero value always shows at least one digit.
   always_comb begin
      lz_blank = 1'b0;
      for (int k = 1; k < NUM_DIGITS; k++) begin
         if ((idx == IW'(k)) && ((disp >> (4*k)) == '0)) lz_blank = 1'b1;
      end
   end
`endif

   always_comb begin
      sel_p0 = '0;
      seg_p0 = 8'h00;
      if (!in_blank) begin
         for (int k = 0; k < NUM_DIGITS; k++) sel_p0[k] = (idx == IW'(k));
         seg_p0 = {decode7(cur_nib), cur_dp};
`ifdef SEG_LZ_BLANK_EN
         if (lz_blank) seg_p0[7:1] = 7'd0;
`endif
      end
   end

   // Output stage: one clock behind tick/idx, polarity applied before the register.
   always_ff @(posedge clk) begin
      if (reset) begin
         segments    <= SEG_OFF;
         digitselect <= SEL_OFF;
      end else begin
         segments    <= ACTIVE_LOW ? ~seg_p0 : seg_p0;
         digitselect <= ACTIVE_LOW ? ~sel_p0 : sel_p0;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with NUM_DIGITS=4, TICK_DIV=4, BLANK_CYCLES=1, ACTIVE_LOW=1.
// Expectations for SEG_LZ_BLANK_EN follow the same macro.
module tb_seg_scan_driver;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic [7:0]  segments;
   logic [3:0]  digitselect;
   logic        frame_done;

   int checks = 0;
   int passes = 0;
   int cyc    = 0;   // clock edges since reset was released

   always #5 clk = ~clk;

   seg_scan_driver #(
      .NUM_DIGITS  (4),
      .TICK_DIV    (4),
      .BLANK_CYCLES(1),
      .ACTIVE_LOW  (1'b1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .segments   (segments),
      .digitselect(digitselect),
      .frame_done (frame_done)
   );

   // Physical (active-low) codes, dp off, hand-derived from the a..g patterns.
   function automatic logic [7:0] seg_code(input logic [3:0] v);
      case (v)
         4'h0:    seg_code = 8'b00000011;
         4'h1:    seg_code = 8'b10011111;
         4'h2:    seg_code = 8'b00100101;
         4'h3:    seg_code = 8'b00001101;
         4'h4:    seg_code = 8'b10011001;
         4'h5:    seg_code = 8'b01001001;
         4'h6:    seg_code = 8'b01000001;
         4'h7:    seg_code = 8'b00011111;
         4'h8:    seg_code = 8'b00000001;
         4'h9:    seg_code = 8'b00001001;
         4'hA:    seg_code = 8'b00010001;
         4'hB:    seg_code = 8'b11000001;
         4'hC:    seg_code = 8'b01100011;
         4'hD:    seg_code = 8'b10000101;
         4'hE:    seg_code = 8'b01100001;
         default: seg_code = 8'b01110001;
      endcase
   endfunction

   // After edge c the outputs reflect the scan state of cycle c-1: tick=(c-1)%4, digit=((c-1)/4)%4.
   function automatic logic [3:0] exp_sel(input int c);
      int s;
      if (c < 1) return 4'b1111;
      s = c - 1;
      if ((s % 4) < 1) return 4'b1111;
      return ~(4'b0001 << ((s / 4) % 4));
   endfunction

   function automatic logic [7:0] exp_seg(input int c, input logic [15:0] d, input logic [3:0] dp);
      int s, i;
      logic [7:0] code;
      if (c < 1) return 8'hFF;
      s = c - 1;
      if ((s % 4) < 1) return 8'hFF;
      i = (s / 4) % 4;
      code = seg_code(d[4*i +: 4]);
`ifdef SEG_LZ_BLANK_EN
      if ((i > 0) && ((d >> (4*i)) == 16'h0)) code = 8'hFF;
`endif
      if (dp[i]) code[0] = 1'b0;
      return code;
   endfunction

   function automatic logic exp_fd(input int c);
      return (c >= 1) && ((c % 16) == 0);
   endfunction

   task automatic test_reset();
      reset = 1'b1; load = 1'b0; digits_in = 16'h0; dp_in = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (digitselect !== 4'b1111) $display("FAIL reset_sel got=%b want=1111", digitselect); else passes++;
      checks++;
      if (segments !== 8'hFF) $display("FAIL reset_seg got=%b want=11111111", segments); else passes++;
      checks++;
      if (frame_done !== 1'b0) $display("FAIL reset_fd got=%b want=0", frame_done); else passes++;
      reset = 1'b0;
      cyc = 0;
      @(posedge clk); #1; cyc++;
      checks++;
      if (digitselect !== 4'b1111) $display("FAIL post_reset_sel got=%b want=1111", digitselect); else passes++;
      checks++;
      if (segments !== 8'hFF) $display("FAIL post_reset_seg got=%b want=11111111", segments); else passes++;
   endtask

   task automatic test_scan();
      while (cyc < 16) begin
         @(posedge clk); #1; cyc++;
         checks++;
         if (digitselect !== exp_sel(cyc)) $display("FAIL scan_sel cyc=%0d got=%b want=%b", cyc, digitselect, exp_sel(cyc)); else passes++;
         checks++;
         if (segments !== exp_seg(cyc, 16'h0, 4'h0)) $display("FAIL scan_seg cyc=%0d got=%b want=%b", cyc, segments, exp_seg(cyc, 16'h0, 4'h0)); else passes++;
         checks++;
         if (frame_done !== exp_fd(cyc)) $display("FAIL scan_fd cyc=%0d got=%b want=%b", cyc, frame_done, exp_fd(cyc)); else passes++;
      end
   endtask

   task automatic test_load_midframe();
      logic [15:0] dexp;
      while (cyc < 48) begin
         load = (cyc + 1 == 21);
         digits_in = load ? 16'h12AF : 16'h0;
         @(posedge clk); #1; cyc++;
         load = 1'b0;
         dexp = (cyc <= 32) ? 16'h0000 : 16'h12AF;
         checks++;
         if (digitselect !== exp_sel(cyc)) $display("FAIL mid_sel cyc=%0d got=%b want=%b", cyc, digitselect, exp_sel(cyc)); else passes++;
         checks++;
         if (segments !== exp_seg(cyc, dexp, 4'h0)) $display("FAIL mid_seg cyc=%0d got=%b want=%b", cyc, segments, exp_seg(cyc, dexp, 4'h0)); else passes++;
         checks++;
         if (frame_done !== exp_fd(cyc)) $display("FAIL mid_fd cyc=%0d got=%b want=%b", cyc, frame_done, exp_fd(cyc)); else passes++;
         if (cyc == 34) begin
            checks++;
            if (segments !== 8'b01110001) $display("FAIL mid_digit0_F got=%b want=01110001", segments); else passes++;
         end
         if (cyc == 38) begin
            checks++;
            if (segments !== 8'b00010001) $display("FAIL mid_digit1_A got=%b want=00010001", segments); else passes++;
         end
      end
   endtask

   task automatic test_two_loads();
      logic [15:0] dexp;
      while (cyc < 80) begin
         load = (cyc + 1 == 52) || (cyc + 1 == 57);
         digits_in = (cyc + 1 == 52) ? 16'h1111 : (cyc + 1 == 57) ? 16'h2222 : 16'h0;
         @(posedge clk); #1; cyc++;
         load = 1'b0;
         dexp = (cyc <= 64) ? 16'h12AF : 16'h2222;
         checks++;
         if (digitselect !== exp_sel(cyc)) $display("FAIL two_sel cyc=%0d got=%b want=%b", cyc, digitselect, exp_sel(cyc)); else passes++;
         checks++;
         if (segments !== exp_seg(cyc, dexp, 4'h0)) $display("FAIL two_seg cyc=%0d got=%b want=%b", cyc, segments, exp_seg(cyc, dexp, 4'h0)); else passes++;
         checks++;
         if (frame_done !== exp_fd(cyc)) $display("FAIL two_fd cyc=%0d got=%b want=%b", cyc, frame_done, exp_fd(cyc)); else passes++;
      end
   endtask

   task automatic test_boundary_load();
      logic [15:0] dexp;
      while (cyc < 128) begin
         load = (cyc + 1 == 96);
         digits_in = load ? 16'h0305 : 16'h0;
         @(posedge clk); #1; cyc++;
         load = 1'b0;
         dexp = (cyc <= 96) ? 16'h2222 : 16'h0305;
         checks++;
         if (digitselect !== exp_sel(cyc)) $display("FAIL bnd_sel cyc=%0d got=%b want=%b", cyc, digitselect, exp_sel(cyc)); else passes++;
         checks++;
         if (segments !== exp_seg(cyc, dexp, 4'h0)) $display("FAIL bnd_seg cyc=%0d got=%b want=%b", cyc, segments, exp_seg(cyc, dexp, 4'h0)); else passes++;
         checks++;
         if (frame_done !== exp_fd(cyc)) $display("FAIL bnd_fd cyc=%0d got=%b want=%b", cyc, frame_done, exp_fd(cyc)); else passes++;
         if (cyc == 96) begin
            checks++;
            if (dut.pending !== 1'b0) $display("FAIL bnd_pending got=%b want=0", dut.pending); else passes++;
         end
      end
   endtask

   task automatic test_reset_midframe();
      while (cyc < 138) begin
         load = (cyc + 1 == 131);
         digits_in = load ? 16'h7777 : 16'h0;
         @(posedge clk); #1; cyc++;
         load = 1'b0;
         checks++;
         if (segments !== exp_seg(cyc, 16'h0305, 4'h0)) $display("FAIL rstm_pre_seg cyc=%0d got=%b want=%b", cyc, segments, exp_seg(cyc, 16'h0305, 4'h0)); else passes++;
      end
      // Edge 139 samples state tick 2 of digit 2 with 7777 pending.
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (digitselect !== 4'b1111) $display("FAIL rstm_sel got=%b want=1111", digitselect); else passes++;
      checks++;
      if (segments !== 8'hFF) $display("FAIL rstm_seg got=%b want=11111111", segments); else passes++;
      checks++;
      if (frame_done !== 1'b0) $display("FAIL rstm_fd got=%b want=0", frame_done); else passes++;
      reset = 1'b0;
      cyc = 0;
      while (cyc < 32) begin
         @(posedge clk); #1; cyc++;
         checks++;
         if (digitselect !== exp_sel(cyc)) $display("FAIL rstm_sel cyc=%0d got=%b want=%b", cyc, digitselect, exp_sel(cyc)); else passes++;
         checks++;
         if (segments !== exp_seg(cyc, 16'h0, 4'h0)) $display("FAIL rstm_seg cyc=%0d got=%b want=%b", cyc, segments, exp_seg(cyc, 16'h0, 4'h0)); else passes++;
         checks++;
         if (frame_done !== exp_fd(cyc)) $display("FAIL rstm_fd cyc=%0d got=%b want=%b", cyc, frame_done, exp_fd(cyc)); else passes++;
      end
   endtask

   task automatic test_lz_dp();
      logic [15:0] dexp;
      logic [3:0]  dpexp;
      logic [7:0]  d3_want, d2_want;
`ifdef SEG_LZ_BLANK_EN
      d3_want = 8'b11111110;
      d2_want = 8'b11111111;
`else
      d3_want = 8'b00000010;
      d2_want = 8'b00000011;
`endif
      while (cyc < 64) begin
         load = (cyc + 1 == 35);
         digits_in = load ? 16'h0040 : 16'h0;
         dp_in = load ? 4'b1000 : 4'b0000;
         @(posedge clk); #1; cyc++;
         load = 1'b0;
         dexp  = (cyc <= 48) ? 16'h0000 : 16'h0040;
         dpexp = (cyc <= 48) ? 4'b0000 : 4'b1000;
         checks++;
         if (segments !== exp_seg(cyc, dexp, dpexp)) $display("FAIL lz_seg cyc=%0d got=%b want=%b", cyc, segments, exp_seg(cyc, dexp, dpexp)); else passes++;
         if (cyc == 62) begin
            checks++;
            if (segments !== d3_want) $display("FAIL lz_digit3 got=%b want=%b", segments, d3_want); else passes++;
         end
         if (cyc == 58) begin
            checks++;
            if (segments !== d2_want) $display("FAIL lz_digit2 got=%b want=%b", segments, d2_want); else passes++;
         end
         if (cyc == 54) begin
            checks++;
            if (segments !== 8'b10011001) $display("FAIL lz_digit1 got=%b want=10011001", segments); else passes++;
         end
         if (cyc == 50) begin
            checks++;
            if (segments !== 8'b00000011) $display("FAIL lz_digit0 got=%b want=00000011", segments); else passes++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_load_midframe();
      test_two_loads();
      test_boundary_load();
      test_reset_midframe();
      test_lz_dp();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
